mandelbrot_pixel_seq: RTL and testbench
=======================================

# mandelbrot_pixel_seq

Per-pixel sequencer that sits directly upstream of the Mandelbrot iteration accelerator. It accepts one complex point (Cr, Ci) per valid/ready transaction and streams both words byte-serially into the accelerator with the load and start strobes. It then counts iterations until the accelerator's escape flag rises or the iteration limit is reached, and returns the escape count on a valid/ready output.

## Interface
- ITER_W, default 8: width of the iteration limit and the result count.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  pixel request valid.
- in_ready  out  1  high only in IDLE.
- in_cr  in  32  real part of C; sampled at the accept edge.
- in_ci  in  32  imaginary part of C; sampled at the accept edge.
- max_iter  in  ITER_W  iteration limit; sampled at the accept edge.
- acc_data_o  out  8  byte bus to the accelerator.
- acc_load_cr_o  out  1  accelerator Cr load strobe.
- acc_load_ci_o  out  1  accelerator Ci load strobe.
- acc_start_o  out  1  accelerator start strobe.
- acc_unbounded_i  in  1  accelerator's registered escape flag. It clears on the edge after start and is sticky afterwards.
- out_valid  out  1  result valid.
- out_ready  in  1  result accepted.
- out_iter  out  ITER_W  escape iteration count.
- out_escaped  out  1  1 = escaped; 0 = limit reached.
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, LOAD_CR, LOAD_CI, ITER, DONE. A 2-bit byte index runs 0..3 in each LOAD state.
- IDLE -> LOAD_CR on in_valid && in_ready. The block latches cr, ci and max_iter at this edge.
- LOAD_CR:
  - Drives byte idx of cr, LSB first: idx 0 = cr[7:0], idx 3 = cr[31:24].
  - acc_load_cr_o = 1 only at idx 3.
  - After idx 3 -> LOAD_CI.
- LOAD_CI:
  - Same byte order for ci.
  - At idx 3, acc_load_ci_o = 1 and acc_start_o = 1 in the same cycle.
  - Then -> ITER with iter cleared to 0.
- ITER, evaluated each cycle:
  - If acc_unbounded_i = 1 -> DONE with out_iter = iter, out_escaped = 1.
  - Else if iter == max_iter_q -> DONE with out_iter = max_iter_q, out_escaped = 0.
  - Else iter <= iter + 1. The counter never wraps.
- DONE: out_valid = 1, with out_iter and out_escaped held stable. On out_ready -> IDLE.
- Accelerator outputs outside the active byte or strobe cycles: acc_data_o = 0, all strobes 0.
- Back-pressure: out_ready low holds DONE indefinitely. No new request is accepted until DONE exits.
- in_valid while busy is ignored and is not queued.
- Reset, including mid-operation:
  - state = IDLE, all accelerator strobes 0, acc_data_o = 0.
  - out_valid = 0, out_iter = 0, out_escaped = 0, busy = 0, in_ready = 1 after release.
  - The accelerator shares rst_n.

## Timing
- Accept edge = cycle 0. acc_data_o carries cr byte 0 in cycle 1.
- Cycle 4: load_cr. Cycle 8: load_ci + start.
- First ITER cycle is cycle 9, with iter = 0.
- Best-case accept-to-out_valid is 10 cycles: unbounded high in cycle 9, out_valid in cycle 10.
- max_iter = 0: out_valid in cycle 10 with out_iter = 0, out_escaped = acc_unbounded_i sampled in cycle 9.
- Limit case: out_valid appears max_iter + 10 cycles after accept.
- Throughput: one pixel per (latency + 1) cycles with out_ready tied high.
- If unbounded and the limit coincide in the same cycle, escape wins: out_escaped = 1.

## Configuration
- MANDEL_SEQ_CR_REUSE_EN defined:
  - The block keeps last_cr and a last_cr_valid flag; reset clears the flag.
  - When the accepted cr equals last_cr and the flag is set, LOAD_CR is skipped and the block goes straight to LOAD_CI. The accelerator retains its pending Cr.
  - Latency drops by 4 cycles. Each completed LOAD_CR updates last_cr and sets the flag.
- Undefined: LOAD_CR always executes; no extra state.

## Test plan
- Reset mid-LOAD_CI (assert rst_n low in cycle 6) -> all accelerator strobes 0 immediately; in_ready = 1 and out_valid = 0 after release.
- Escape case:
  - Stimulus: cr = 0x12345678, ci = 0x9ABCDEF0, max_iter = 50; stub raises unbounded 5 ITER cycles after start.
  - Byte stream must be 78,56,34,12,F0,DE,BC,9A, with load_cr on byte 4 and load_ci + start on byte 8.
  - Required result: out_iter = 5, out_escaped = 1, out_valid in cycle 15.
- Limit and back-pressure: stub never escapes, max_iter = 20, out_ready held low 3 cycles -> out_iter = 20, out_escaped = 0, out_valid in cycle 30 and held stable until out_ready.
- Limit boundaries:
  - max_iter = 0 with stub idle -> out_iter = 0, out_escaped = 0 in cycle 10.
  - max_iter = 255 -> out_iter = 255 with no wrap.
- Coincidence: unbounded rises exactly when iter == max_iter = 7 -> out_iter = 7, out_escaped = 1.
- With MANDEL_SEQ_CR_REUSE_EN, two back-to-back pixels with equal cr:
  - Second pixel shows no load_cr; start occurs 4 cycles after accept.
  - A third pixel with a different cr performs the full LOAD_CR.

Source files
------------

// File: rtl/mandelbrot_pixel_seq_if.sv
// Pixel request / result handshake bundle for mandelbrot_pixel_seq.
// master: requester side (drives in_*, out_ready); slave: the sequencer.
interface mandelbrot_pixel_seq_if #(
    parameter int ITER_W = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_cr;
    logic [31:0]       in_ci;
    logic [ITER_W-1:0] max_iter;
    logic              out_valid;
    logic              out_ready;
    logic [ITER_W-1:0] out_iter;
    logic              out_escaped;

    modport master (
        output in_valid, in_cr, in_ci, max_iter, out_ready,
        input  in_ready, out_valid, out_iter, out_escaped
    );

    modport slave (
        input  in_valid, in_cr, in_ci, max_iter, out_ready,
        output in_ready, out_valid, out_iter, out_escaped
    );
endinterface

// File: rtl/mandelbrot_pixel_seq.sv
// Per-pixel sequencer: byte-serial Cr/Ci load into the Mandelbrot
// accelerator, then counts iterations until escape or limit.
// Ports: clk, rst_n (async active-low); px (slave): pixel request
// in_valid/in_ready/in_cr/in_ci/max_iter and result out_valid/out_ready/
// out_iter/out_escaped; acc_data_o, acc_load_cr_o, acc_load_ci_o,
// acc_start_o to the accelerator; acc_unbounded_i from it; busy.
// Option: define MANDEL_SEQ_CR_REUSE_EN to skip LOAD_CR when the new
// Cr matches the last one already loaded into the accelerator.
module mandelbrot_pixel_seq #(
    parameter int ITER_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    mandelbrot_pixel_seq_if.slave px,
    output logic [7:0]          acc_data_o,
    output logic                acc_load_cr_o,
    output logic                acc_load_ci_o,
    output logic                acc_start_o,
    input  logic                acc_unbounded_i,
    output logic                busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_CR,
        LOAD_CI,
        ITER,
        DONE
    } state_t;

    state_t            state;
    logic [1:0]        idx;
    logic [31:0]       cr_q;
    logic [31:0]       ci_q;
    logic [ITER_W-1:0] max_q;
    logic [ITER_W-1:0] iter;
    logic              out_valid_q;
    logic [ITER_W-1:0] out_iter_q;
    logic              out_esc_q;
    logic              reuse_hit;

`ifdef MANDEL_SEQ_CR_REUSE_EN
    logic [31:0] last_cr;
    logic        last_cr_valid;
    assign reuse_hit = last_cr_valid && (px.in_cr == last_cr);
`else
    assign reuse_hit = 1'b0;
`endif

    function automatic logic [7:0] byte_of(
        input logic [31:0] w,
        input logic [1:0]  i
    );
        logic [7:0] b;
        unique case (i)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    assign px.in_ready    = (state == IDLE);
    assign busy           = (state != IDLE);
    assign px.out_valid   = out_valid_q;
    assign px.out_iter    = out_iter_q;
    assign px.out_escaped = out_esc_q;

    // Accelerator outputs are registered one cycle ahead: the value
    // loaded at an edge is what the accelerator sees in the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= 2'd0;
            cr_q          <= '0;
            ci_q          <= '0;
            max_q         <= '0;
            iter          <= '0;
            out_valid_q   <= 1'b0;
            out_iter_q    <= '0;
            out_esc_q     <= 1'b0;
            acc_data_o    <= 8'd0;
            acc_load_cr_o <= 1'b0;
            acc_load_ci_o <= 1'b0;
            acc_start_o   <= 1'b0;
`ifdef MANDEL_SEQ_CR_REUSE_EN
            last_cr       <= '0;
            last_cr_valid <= 1'b0;
`endif
        end else begin
            acc_data_o    <= 8'd0;
            acc_load_cr_o <= 1'b0;
            acc_load_ci_o <= 1'b0;
            acc_start_o   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (px.in_valid) begin
                        cr_q  <= px.in_cr;
                        ci_q  <= px.in_ci;
                        max_q <= px.max_iter;
                        idx   <= 2'd0;
                        if (reuse_hit) begin
                            state      <= LOAD_CI;
                            acc_data_o <= px.in_ci[7:0];
                        end else begin
                            state      <= LOAD_CR;
                            acc_data_o <= px.in_cr[7:0];
                        end
                    end
                end
                LOAD_CR: begin
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        state      <= LOAD_CI;
                        acc_data_o <= ci_q[7:0];
`ifdef MANDEL_SEQ_CR_REUSE_EN
                        last_cr       <= cr_q;
                        last_cr_valid <= 1'b1;
`endif
                    end else begin
                        acc_data_o    <= byte_of(cr_q, idx + 2'd1);
                        acc_load_cr_o <= (idx == 2'd2);
                    end
                end
                LOAD_CI: begin
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        state <= ITER;
                        iter  <= '0;
                    end else begin
                        acc_data_o    <= byte_of(ci_q, idx + 2'd1);
                        acc_load_ci_o <= (idx == 2'd2);
                        acc_start_o   <= (idx == 2'd2);
                    end
                end
                ITER: begin
                    // Escape is tested first so it wins a tie with the limit.
                    if (acc_unbounded_i) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        out_iter_q  <= iter;
                        out_esc_q   <= 1'b1;
                    end else if (iter == max_q) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        out_iter_q  <= max_q;
                        out_esc_q   <= 1'b0;
                    end else begin
                        iter <= iter + 1'b1;
                    end
                end
                DONE: begin
                    if (px.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mandelbrot_pixel_seq.sv
// Testbench for mandelbrot_pixel_seq: vector table plus reset sequence,
// accelerator escape stub and result scoreboard.
module tb_mandelbrot_pixel_seq;

    localparam int NEVER = 32'h7fff_ffff;
`ifdef MANDEL_SEQ_CR_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    typedef struct {
        logic [31:0] cr;
        logic [31:0] ci;
        logic [7:0]  max_iter;
        int          esc_at;
        int          ready_delay;
        bit          noise;
        logic [7:0]  exp_iter;
        logic        exp_esc;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [7:0] iter;
        logic       esc;
    } res_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] acc_data_o;
    logic       acc_load_cr_o;
    logic       acc_load_ci_o;
    logic       acc_start_o;
    logic       busy;
    logic       stub_unb;
    int         stub_cnt;
    int         esc_at;
    int         errors;
    int         checks;
    res_t       sb[$];
    logic [31:0] m_last_cr;
    bit          m_last_valid;

    mandelbrot_pixel_seq_if #(.ITER_W(8)) px ();

    mandelbrot_pixel_seq #(.ITER_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .px              (px),
        .acc_data_o      (acc_data_o),
        .acc_load_cr_o   (acc_load_cr_o),
        .acc_load_ci_o   (acc_load_ci_o),
        .acc_start_o     (acc_start_o),
        .acc_unbounded_i (stub_unb),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accelerator stub: flag clears on the edge after start, then rises
    // esc_at ITER cycles later and stays high.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_unb <= 1'b0;
            stub_cnt <= 0;
        end else if (acc_start_o) begin
            stub_cnt <= 0;
            stub_unb <= (esc_at == 0);
        end else begin
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt + 1 >= esc_at) stub_unb <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && px.out_valid && px.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL result: unexpected iter=%0d esc=%b, no entry queued",
                         px.out_iter, px.out_escaped);
            end else begin
                res_t e;
                e = sb.pop_front();
                if (px.out_iter !== e.iter || px.out_escaped !== e.esc) begin
                    errors++;
                    $display("FAIL result: got iter=%0d esc=%b, want iter=%0d esc=%b",
                             px.out_iter, px.out_escaped, e.iter, e.esc);
                end
            end
        end
    end

    function automatic logic [7:0] exp_byte(input logic [31:0] w, input int i);
        logic [31:0] t;
        t = w >> (8 * i);
        return t[7:0];
    endfunction

    task automatic check_idle_state(input string name);
        checks++;
        if (px.in_ready !== 1'b1 || px.out_valid !== 1'b0 || busy !== 1'b0 ||
            px.out_iter !== 8'd0 || px.out_escaped !== 1'b0) begin
            errors++;
            $display("FAIL %s: got rdy=%b vld=%b busy=%b iter=%0d esc=%b, want 1 0 0 0 0",
                     name, px.in_ready, px.out_valid, busy, px.out_iter, px.out_escaped);
        end
        checks++;
        if (acc_data_o !== 8'd0 || acc_load_cr_o !== 1'b0 ||
            acc_load_ci_o !== 1'b0 || acc_start_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_acc: got data=%h lcr=%b lci=%b st=%b, want all 0",
                     name, acc_data_o, acc_load_cr_o, acc_load_ci_o, acc_start_o);
        end
    endtask

    task automatic run_vec(input int n, input vec_t v);
        bit   reuse;
        int   off;
        int   lat;
        int   c;
        int   w;
        bit   got;
        bit   sok;
        bit   hok;
        res_t r;
        logic [7:0] eb;
        logic elcr;
        logic elci;
        string smsg;

        reuse = REUSE && m_last_valid && (v.cr == m_last_cr);
        if (!reuse) begin
            m_last_cr    = v.cr;
            m_last_valid = 1'b1;
        end
        off = reuse ? 4 : 0;
        lat = v.exp_lat - off;
        esc_at = v.esc_at;
        r.iter = v.exp_iter;
        r.esc  = v.exp_esc;
        sb.push_back(r);

        w = 0;
        @(negedge clk);
        while (!px.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        px.in_valid = 1'b1;
        px.in_cr    = v.cr;
        px.in_ci    = v.ci;
        px.max_iter = v.max_iter;
        @(posedge clk);
        #1;
        if (v.noise) px.in_cr = ~v.cr;
        else px.in_valid = 1'b0;

        c = 0;
        got = 0;
        sok = 1;
        smsg = "";
        while (c < 600 && !got) begin
            int s;
            @(negedge clk);
            c++;
            if (v.noise && c == 5) px.in_valid = 1'b0;
            s = c - 1 + off;
            if (s < 8) begin
                eb   = (s < 4) ? exp_byte(v.cr, s) : exp_byte(v.ci, s - 4);
                elcr = (s == 3);
                elci = (s == 7);
            end else begin
                eb   = 8'd0;
                elcr = 1'b0;
                elci = 1'b0;
            end
            if (sok && (acc_data_o !== eb || acc_load_cr_o !== elcr ||
                        acc_load_ci_o !== elci || acc_start_o !== elci)) begin
                sok = 0;
                smsg = $sformatf("cycle %0d got data=%h lcr=%b lci=%b st=%b, want data=%h lcr=%b lci=%b st=%b",
                                 c, acc_data_o, acc_load_cr_o, acc_load_ci_o,
                                 acc_start_o, eb, elcr, elci, elci);
            end
            if (px.out_valid) got = 1;
        end

        checks++;
        if (!sok) begin
            errors++;
            $display("FAIL stream vec%0d: %s", n, smsg);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL latency vec%0d: got timeout after %0d cycles, want %0d", n, c, lat);
            void'(sb.pop_back());
            return;
        end else if (c != lat) begin
            errors++;
            $display("FAIL latency vec%0d: got %0d cycles, want %0d", n, c, lat);
        end

        hok = 1;
        for (int d = 0; d < v.ready_delay; d++) begin
            @(negedge clk);
            if (px.out_valid !== 1'b1 || px.out_iter !== v.exp_iter ||
                px.out_escaped !== v.exp_esc) hok = 0;
        end
        if (v.ready_delay > 0) begin
            checks++;
            if (!hok) begin
                errors++;
                $display("FAIL hold vec%0d: got vld=%b iter=%0d esc=%b, want 1 %0d %b",
                         n, px.out_valid, px.out_iter, px.out_escaped,
                         v.exp_iter, v.exp_esc);
            end
        end

        @(posedge clk);
        #1 px.out_ready = 1'b1;
        @(posedge clk);
        #1 px.out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || px.in_ready !== 1'b1 || px.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL release vec%0d: got busy=%b rdy=%b vld=%b, want 0 1 0",
                     n, busy, px.in_ready, px.out_valid);
        end
    endtask

    vec_t vt[9];

    initial begin
        errors = 0;
        checks = 0;
        m_last_cr = '0;
        m_last_valid = 1'b0;
        esc_at = NEVER;
        rst_n = 1'b0;
        px.in_valid = 1'b0;
        px.in_cr = '0;
        px.in_ci = '0;
        px.max_iter = '0;
        px.out_ready = 1'b0;

        //        cr            ci            max   esc    rd noise it   esc lat
        vt[0] = '{32'h12345678, 32'h9ABCDEF0, 8'd50,  5,     0, 0, 8'd5,   1, 15};
        vt[1] = '{32'h00000000, 32'h00000000, 8'd20,  NEVER, 3, 0, 8'd20,  0, 30};
        vt[2] = '{32'h11111111, 32'h00000022, 8'd0,   NEVER, 0, 0, 8'd0,   0, 10};
        vt[3] = '{32'h11111111, 32'h00000033, 8'd7,   7,     0, 0, 8'd7,   1, 17};
        vt[4] = '{32'h11111111, 32'h00000044, 8'd3,   0,     1, 0, 8'd0,   1, 10};
        vt[5] = '{32'hDEADBEEF, 32'h00000001, 8'd255, NEVER, 0, 0, 8'd255, 0, 265};
        vt[6] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 8'd100, 40,    2, 1, 8'd40,  1, 50};
        vt[7] = '{32'h00000001, 32'h00000002, 8'd0,   0,     0, 0, 8'd0,   1, 10};
        vt[8] = '{32'hCAFEF00D, 32'h11223344, 8'd4,   NEVER, 0, 0, 8'd4,   0, 14};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_state("reset");

        for (int i = 0; i < 8; i++) run_vec(i, vt[i]);

        // Reset in the middle of LOAD_CI.
        esc_at = NEVER;
        @(negedge clk);
        px.in_valid = 1'b1;
        px.in_cr    = 32'hCAFEF00D;
        px.in_ci    = 32'h11223344;
        px.max_iter = 8'd10;
        @(posedge clk);
        #1 px.in_valid = 1'b0;
        for (int c = 1; c <= 6; c++) @(negedge clk);
        checks++;
        if (acc_data_o !== 8'h33 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got data=%h busy=%b, want 33 1", acc_data_o, busy);
        end
        #1 rst_n = 1'b0;
        #1;
        check_idle_state("async_reset");
        m_last_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_state("post_reset");

        run_vec(8, vt[8]);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d results outstanding, want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
